// File: rtl/hbm_arb_pkg.sv
// Shared types for the HBM channel arbiter: FSM states and the read-tag record
// that steers returned beats back to their requester.
package hbm_arb_pkg;

    localparam int HBM_DATA_WIDTH = 256;
    // Tag fields are sized for the largest legal configuration (8 requesters, 8-bit length)
    localparam int TAG_ID_W       = 3;
    localparam int TAG_LEN_W      = 8;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [TAG_ID_W-1:0]  id;
        logic [TAG_LEN_W-1:0] len;
    } arb_tag_t;

endpackage

// File: rtl/hbm_arb_tag_fifo.sv
// In-order read-tag FIFO; a pop frees its slot for a push in the same cycle.
module hbm_arb_tag_fifo
    import hbm_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  arb_tag_t push_tag,
    input  logic     pop,
    output arb_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr, rd_ptr;
    arb_tag_t    mem [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_tag;
    end

endmodule

// File: rtl/hbm_channel_arbiter.sv
// Round-robin arbiter sharing one HBM channel among NUM_REQ requesters, with write-burst
// locking and in-order routing of read-response beats.
module hbm_channel_arbiter
    import hbm_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = HBM_DATA_WIDTH,
    parameter int LEN_W           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      hbm_cmd_valid,
    input  logic                      hbm_cmd_ready,
    output logic                      hbm_cmd_first,
    output logic                      hbm_cmd_write,
    output logic [ADDR_W-1:0]         hbm_cmd_addr,
    output logic [LEN_W-1:0]          hbm_cmd_len,
    output logic [DATA_W-1:0]         hbm_wdata,
    input  logic                      hbm_rvalid,
    input  logic [DATA_W-1:0]         hbm_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_last,
    output logic                      err_unexp_rsp
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t        state;
    logic [IDW-1:0]    rr_ptr, owner, win_id;
    logic              win_found;
    logic [LEN_W-1:0]  wr_cnt, rd_cnt, hold_len, win_len;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_write;
    logic              hs, push, pop, rsp_hit, fifo_full, fifo_empty;
    arb_tag_t          push_tag, head;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + IDW'(1);
    endfunction

    // Cyclic scan from rr_ptr; reads are skipped while the tag FIFO is full
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] cand;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
            cand = sum[IDW-1:0];
            if (!win_found && req_valid[cand] && (req_write[cand] || !fifo_full)) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_len = req_len[win_id*LEN_W +: LEN_W];

    always_comb begin
        hbm_cmd_valid = 1'b0;
        hbm_cmd_first = 1'b0;
        hbm_cmd_write = 1'b0;
        hbm_cmd_addr  = '0;
        hbm_cmd_len   = '0;
        hbm_wdata     = '0;
        req_ready     = '0;
        if (rst_n) begin
            if (state == WR_BURST) begin
                req_ready[owner] = hbm_cmd_ready;
                if (req_valid[owner]) begin
                    hbm_cmd_valid = 1'b1;
                    hbm_cmd_write = hold_write;
                    hbm_cmd_addr  = hold_addr;
                    hbm_cmd_len   = hold_len;
                    hbm_wdata     = req_wdata[owner*DATA_W +: DATA_W];
                end
            end else if (win_found) begin
                req_ready[win_id] = hbm_cmd_ready;
                hbm_cmd_valid     = 1'b1;
                hbm_cmd_first     = 1'b1;
                hbm_cmd_write     = req_write[win_id];
                hbm_cmd_addr      = req_addr[win_id*ADDR_W +: ADDR_W];
                hbm_cmd_len       = win_len;
                hbm_wdata         = req_wdata[win_id*DATA_W +: DATA_W];
            end
        end
    end

    assign hs           = hbm_cmd_valid & hbm_cmd_ready;
    assign push         = hs & (state == IDLE) & ~req_write[win_id];
    assign push_tag.id  = TAG_ID_W'(win_id);
    assign push_tag.len = TAG_LEN_W'(win_len);

    assign rsp_hit  = hbm_rvalid & ~fifo_empty;
    assign rsp_last = rsp_hit & (TAG_LEN_W'(rd_cnt) == head.len);
    assign pop      = rsp_last;
    assign rsp_data = rsp_hit ? hbm_rdata : '0;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = rsp_hit && (head.id == TAG_ID_W'(i));
    end

    hbm_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            hold_addr     <= '0;
            hold_len      <= '0;
            hold_write    <= 1'b0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (hbm_rvalid && fifo_empty) err_unexp_rsp <= 1'b1;
            if (rsp_hit) rd_cnt <= rsp_last ? '0 : rd_cnt + LEN_W'(1);
            case (state)
                IDLE: if (hs) begin
                    if (!req_write[win_id] || win_len == '0) begin
                        rr_ptr <= next_id(win_id);
                    end else begin
                        owner      <= win_id;
                        wr_cnt     <= win_len;
                        hold_addr  <= req_addr[win_id*ADDR_W +: ADDR_W];
                        hold_len   <= win_len;
                        hold_write <= 1'b1;
                        state      <= WR_BURST;
                    end
                end
                WR_BURST: if (hs) begin
                    wr_cnt <= wr_cnt - LEN_W'(1);
                    if (wr_cnt == LEN_W'(1)) begin
                        state  <= IDLE;
                        rr_ptr <= next_id(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hbm_channel_arbiter.md
Name: hbm_channel_arbiter

Overview:
Shares one HBM channel between NUM_REQ on-chip requesters (cores, TPU/VPU DMA) using round-robin arbitration with burst locking. Forwards commands and write beats to the channel. Routes read-response beats back to the originating requester through an in-order tag FIFO. Sits between the NoC/DMA clients and one per-channel HBM controller inside riscv_ai_chip; one instance per HBM channel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, byte address width
DATA_W, 256, beat width (HBM_DATA_WIDTH)
LEN_W, 4, burst length field; value = beats-1 (1..16 beats)
MAX_OUTSTANDING, 8, read-tag FIFO depth (power of 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accept
req_write  in  NUM_REQ  1=write burst, 0=read; sampled on first beat
req_addr  in  NUM_REQ*ADDR_W  burst address; sampled on first beat
req_len  in  NUM_REQ*LEN_W  beats-1; sampled on first beat
req_wdata  in  NUM_REQ*DATA_W  write beat data
hbm_cmd_valid  out  1  beat to channel valid
hbm_cmd_ready  in  1  channel accepts beat
hbm_cmd_first  out  1  first beat of burst (addr/len/write valid)
hbm_cmd_write  out  1  burst direction
hbm_cmd_addr  out  ADDR_W  burst address
hbm_cmd_len  out  LEN_W  beats-1
hbm_wdata  out  DATA_W  write data
hbm_rvalid  in  1  read beat returned (no backpressure)
hbm_rdata  in  DATA_W  read data
rsp_valid  out  NUM_REQ  one-hot read beat to requester
rsp_data  out  DATA_W  read data, broadcast
rsp_last  out  1  final beat of read burst
err_unexp_rsp  out  1  sticky: hbm_rvalid with empty tag FIFO

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = 0 (requester 0 highest priority); tag FIFO empty; beat counters 0; err cleared.
- FSM states IDLE, WR_BURST.
- IDLE: winner = first valid requester at or after rr pointer, cyclically. A read candidate is eligible only if the tag FIFO is not full; ineligible candidates are skipped. The winner's fields drive hbm_cmd_* combinationally with hbm_cmd_first=1. req_ready[winner] = hbm_cmd_ready. All other req_ready are 0.
- Handshake = hbm_cmd_valid & hbm_cmd_ready.
- Read handshake: push {winner id, len} into the tag FIFO; rr pointer = winner+1 (mod NUM_REQ); stay IDLE. A read occupies 1 command beat.
- Write handshake with len=0: rr pointer advances; stay IDLE.
- Write handshake with len>0: lock owner = winner, wr_cnt = len, go to WR_BURST.
- WR_BURST: only the owner is forwarded, with hbm_cmd_first=0 and hbm_cmd_addr/len/write held at their registered values. Each handshake decrements wr_cnt. The handshake with wr_cnt=1 is the last beat: return to IDLE and set rr pointer = owner+1. Other requesters' req_valid are ignored; no preemption.
- Read response path:
  - Head of FIFO gives {id, len}. On hbm_rvalid: rsp_valid[id]=1 in the same cycle (combinational), rsp_data=hbm_rdata, and rd_cnt increments.
  - rsp_last = (rd_cnt==head.len). On the last beat, pop the FIFO and clear rd_cnt.
- FIFO push and pop in the same cycle are legal, including when full: the pop frees the slot, but eligibility uses the registered full flag.
- hbm_rvalid with the FIFO empty: rsp_valid stays 0; err_unexp_rsp sets and holds until reset.
- Requester deasserting req_valid mid-write-burst: arbiter waits in WR_BURST (bubbles allowed).
- Asynchronous reset mid-burst: everything returns immediately to reset values; in-flight reads are dropped.
- Latency: command path 0 cycles (combinational mux); response path 0 cycles.
- Counter widths: wr_cnt/rd_cnt are LEN_W bits; FIFO pointers are log2(MAX_OUTSTANDING)+1 bits.

Decomposition:
- Package hbm_arb_pkg: state enum (IDLE, WR_BURST), tag struct {id[$clog2(NUM_REQ)], len[LEN_W]}, DATA_W default taken from HBM_DATA_WIDTH.
- Sub-module hbm_arb_tag_fifo: synchronous FIFO with full/empty flags and simultaneous push/pop support.

Test Plan:
- Requesters 0,1,2 each issue a single read (len=0), all valid at cycle 0, hbm_cmd_ready=1 -> grants in order 0,1,2 on consecutive cycles; three returned beats yield rsp_valid = 0001, 0010, 0100 with rsp_last=1 each.
- Requester 1 writes len=3 while requester 0 holds valid -> 4 beats for requester 1 back-to-back, req_ready[0]=0 throughout; requester 0 granted on the cycle after the last beat; rr pointer = 2 afterward.
- 8 reads outstanding (FIFO full), then a 9th read and a write pending -> write granted and read skipped; the read is granted the cycle after the first response pop.
- Read len=15 from requester 3 -> 16 response beats all with rsp_valid=1000; rsp_last only on beat 16; FIFO empty afterward.
- hbm_rvalid pulse with no outstanding reads -> err_unexp_rsp=1 and sticky, rsp_valid=0; cleared only by rst_n.
- rst_n asserted in the middle of a write burst (beat 2 of 4) -> all outputs 0 immediately; after release, requester 0 wins first.
